// File: rtl/sha256_pkg.sv
// Shared SHA-256 types and constants: word type, round constants, initial hash value, FSM encoding.
package sha256_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam word_t K_ROM [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam word_t IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

endpackage

// File: rtl/func_sigma0.sv
// SHA-256 big Sigma0: ROTR2 ^ ROTR13 ^ ROTR22, applied to working variable a.
module func_sigma0 (
    input  logic [31:0] x,
    output logic [31:0] y
);
    assign y = {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
endmodule

// File: rtl/func_sigma1.sv
// SHA-256 big Sigma1: ROTR6 ^ ROTR11 ^ ROTR25, applied to working variable e.
module func_sigma1 (
    input  logic [31:0] x,
    output logic [31:0] y
);
    assign y = {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
endmodule

// File: rtl/func_ssigma0.sv
// SHA-256 small sigma0 for the message schedule: ROTR7 ^ ROTR18 ^ SHR3.
module func_ssigma0 (
    input  logic [31:0] x,
    output logic [31:0] y
);
    assign y = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
endmodule

// File: rtl/func_ssigma1.sv
// SHA-256 small sigma1 for the message schedule: ROTR17 ^ ROTR19 ^ SHR10.
module func_ssigma1 (
    input  logic [31:0] x,
    output logic [31:0] y
);
    assign y = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
endmodule

// File: rtl/sha256_w_window.sv
// 16-word message-schedule window: loads a block, then shifts one word per round and supplies W_t.
module sha256_w_window
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic         expand,
    input  logic [511:0] block_in,
    output logic [31:0]  wt
);

    word_t win_r [0:15];
    word_t ss0_s;
    word_t ss1_s;
    word_t wnew_s;

    func_ssigma0 u_ss0 (.x(win_r[1]),  .y(ss0_s));
    func_ssigma1 u_ss1 (.x(win_r[14]), .y(ss1_s));

    // W_t select: raw block word for rounds 0..15, schedule expansion afterwards
    always_comb begin
        wnew_s = win_r[0];
        if (expand) begin
            wnew_s = ss1_s + win_r[9] + ss0_s + win_r[0];
        end else begin
            wnew_s = win_r[0];
        end
    end

    assign wt = wnew_s;

    // Window register; early rounds rotate so W0..W15 are back in place when expansion starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                win_r[i] <= 32'h00000000;
            end
        end else if (load) begin
            for (int i = 0; i < 16; i++) begin
                win_r[i] <= block_in[511 - 32*i -: 32];
            end
        end else if (shift) begin
            for (int i = 0; i < 15; i++) begin
                win_r[i] <= win_r[i + 1];
            end
            win_r[15] <= wnew_s;
        end
    end

endmodule

// File: rtl/sha256_compress.sv
// Iterative SHA-256 compression engine, one round per clock.
// Optional SHA256_FEEDFORWARD_EN adds the final H+abcdefgh feed-forward stage.
module sha256_compress
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] block_in,
    input  logic [255:0] hash_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] digest
);

    state_t       state_r;
    state_t       state_nxt_s;
    logic [5:0]   t_r;
    word_t        a_r, b_r, c_r, d_r, e_r, f_r, g_r, h_r;
    logic [255:0] digest_r;
    logic         in_ready_r;
    logic         out_valid_r;

    word_t        wt_s, bs0_s, bs1_s, ch_s, maj_s, t1_s, t2_s, a_nxt_s, e_nxt_s;
    logic         accept_s;
    logic         round_s;
    logic         last_s;
    logic         expand_s;

    assign accept_s = in_valid && (state_r == ST_IDLE);
    assign round_s  = (state_r == ST_ROUND);
    assign last_s   = round_s && (t_r == 6'd63);
    assign expand_s = (t_r[5:4] != 2'b00);

    func_sigma0 u_bs0 (.x(a_r), .y(bs0_s));
    func_sigma1 u_bs1 (.x(e_r), .y(bs1_s));

    sha256_w_window u_win (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept_s),
        .shift    (round_s),
        .expand   (expand_s),
        .block_in (block_in),
        .wt       (wt_s)
    );

    // One compression round
    always_comb begin
        ch_s    = (e_r & f_r) ^ (~e_r & g_r);
        maj_s   = (a_r & b_r) ^ (a_r & c_r) ^ (b_r & c_r);
        t1_s    = h_r + bs1_s + ch_s + K_ROM[t_r] + wt_s;
        t2_s    = bs0_s + maj_s;
        a_nxt_s = t1_s + t2_s;
        e_nxt_s = d_r + t1_s;
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) state_nxt_s = ST_ROUND;
                else          state_nxt_s = ST_IDLE;
            end
            ST_ROUND: begin
                if (t_r == 6'd63) begin
`ifdef SHA256_FEEDFORWARD_EN
                    state_nxt_s = ST_FINAL;
`else
                    state_nxt_s = ST_HOLD;
`endif
                end else begin
                    state_nxt_s = ST_ROUND;
                end
            end
            ST_FINAL: state_nxt_s = ST_HOLD;
            ST_HOLD: begin
                if (out_ready) state_nxt_s = ST_IDLE;
                else           state_nxt_s = ST_HOLD;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register with handshake outputs registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_IDLE);
            out_valid_r <= (state_nxt_s == ST_HOLD);
        end
    end

    // Working variables and round counter; counter wraps to 0 on the last round
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_r <= 6'd0;
            a_r <= 32'h0; b_r <= 32'h0; c_r <= 32'h0; d_r <= 32'h0;
            e_r <= 32'h0; f_r <= 32'h0; g_r <= 32'h0; h_r <= 32'h0;
        end else if (accept_s) begin
            t_r <= 6'd0;
            a_r <= hash_in[255:224]; b_r <= hash_in[223:192];
            c_r <= hash_in[191:160]; d_r <= hash_in[159:128];
            e_r <= hash_in[127:96];  f_r <= hash_in[95:64];
            g_r <= hash_in[63:32];   h_r <= hash_in[31:0];
        end else if (round_s) begin
            t_r <= t_r + 6'd1;
            a_r <= a_nxt_s; b_r <= a_r; c_r <= b_r; d_r <= c_r;
            e_r <= e_nxt_s; f_r <= e_r; g_r <= f_r; h_r <= g_r;
        end
    end

`ifdef SHA256_FEEDFORWARD_EN
    word_t hc_r [0:7];

    // Chaining-value copy for the feed-forward add
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                hc_r[i] <= 32'h0;
            end
        end else if (accept_s) begin
            for (int i = 0; i < 8; i++) begin
                hc_r[i] <= hash_in[255 - 32*i -: 32];
            end
        end
    end

    // Digest register: full compression output captured in FINAL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digest_r <= 256'h0;
        end else if (state_r == ST_FINAL) begin
            digest_r <= {a_r + hc_r[0], b_r + hc_r[1], c_r + hc_r[2], d_r + hc_r[3],
                         e_r + hc_r[4], f_r + hc_r[5], g_r + hc_r[6], h_r + hc_r[7]};
        end
    end
`else
    // Digest register: raw working variables captured straight out of the last round
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digest_r <= 256'h0;
        end else if (last_s) begin
            digest_r <= {a_nxt_s, a_r, b_r, c_r, e_nxt_s, e_r, f_r, g_r};
        end
    end
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign digest    = digest_r;

endmodule

// File: tb/tb_sha256_compress.sv
// Directed bench for sha256_compress: known vectors, reference-model vectors, backpressure, back-to-back, reset abort.
module tb_sha256_compress;
    import sha256_pkg::*;

`ifdef SHA256_FEEDFORWARD_EN
    localparam bit FF_EN = 1'b1;
    localparam int LAT   = 66;
`else
    localparam bit FF_EN = 1'b0;
    localparam int LAT   = 65;
`endif

    localparam logic [255:0] ABC_FULL   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] EMPTY_FULL = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [511:0] ABC_BLK    = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK  = {32'h80000000, 480'h0};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] block_in;
    logic [255:0] hash_in;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] digest;

    logic [255:0] exp_q [$];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [255:0] iv_vec;
    logic [255:0] exp_abc;
    logic [255:0] exp_empty;
    logic [511:0] rblk;
    logic [255:0] rhsh;

    sha256_compress dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .block_in  (block_in),
        .hash_in   (hash_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .digest    (digest)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Independent reference: raw a..h after 64 rounds
    function automatic logic [255:0] ref_raw(input logic [511:0] blk, input logic [255:0] hsh);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2, s0, s1;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        for (int i = 0; i < 8; i++) v[i] = hsh[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_ROM[t] + w[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int k = 7; k > 0; k--) v[k] = v[k-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = v[i];
        return r;
    endfunction

    // Expected output from a raw result
    function automatic logic [255:0] from_raw(input logic [255:0] raw, input logic [255:0] hsh);
        logic [255:0] r = raw;
        if (FF_EN) begin
            for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = raw[255 - 32*i -: 32] + hsh[255 - 32*i -: 32];
        end
        return r;
    endfunction

    // Expected output from a full (feed-forward) digest
    function automatic logic [255:0] from_full(input logic [255:0] full, input logic [255:0] hsh);
        logic [255:0] r = full;
        if (!FF_EN) begin
            for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = full[255 - 32*i -: 32] - hsh[255 - 32*i -: 32];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic accept(input logic [511:0] blk, input logic [255:0] hsh, input logic [255:0] expv);
        @(negedge clk);
        block_in = blk;
        hash_in  = hsh;
        in_valid = 1'b1;
        chk("accept_in_ready", {255'd0, in_ready}, 256'd1);
        @(posedge clk);
        exp_q.push_back(expv);
        #1 in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid, counting the accept edge as cycle 1
    task automatic collect(input string tag, input int lat);
        int   cnt = 1;
        logic got = 1'b0;
        while (!got && cnt < 300) begin
            @(posedge clk);
            cnt++;
            #1 got = out_valid;
        end
        chk({tag, "_latency"}, 256'(cnt), 256'(lat));
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_nonempty"}, 256'd0, 256'd1);
        end else begin
            chk({tag, "_digest"}, digest, exp_q.pop_front());
        end
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({tag, "_valid_drop"}, {255'd0, out_valid}, 256'd0);
        chk({tag, "_ready_back"}, {255'd0, in_ready}, 256'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        block_in  = 512'h0;
        hash_in   = 256'h0;
        for (int i = 0; i < 8; i++) iv_vec[255 - 32*i -: 32] = IV[i];
        exp_abc   = from_full(ABC_FULL, iv_vec);
        exp_empty = from_full(EMPTY_FULL, iv_vec);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", {255'd0, in_ready}, 256'd1);
        chk("reset_out_valid", {255'd0, out_valid}, 256'd0);
        chk("reset_digest", digest, 256'd0);
        @(negedge clk) rst_n = 1'b1;

        // "abc" and empty message from the IV
        accept(ABC_BLK, iv_vec, exp_abc);
        collect("abc", LAT);
        release_out("abc");
        accept(EMPTY_BLK, iv_vec, exp_empty);
        collect("empty", LAT);
        release_out("empty");

        // Random blocks and chaining values against the reference model
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 16; i++) rblk[511 - 32*i -: 32] = $urandom;
            for (int i = 0; i < 8; i++)  rhsh[255 - 32*i -: 32] = $urandom;
            accept(rblk, rhsh, from_raw(ref_raw(rblk, rhsh), rhsh));
            collect("random", LAT);
            release_out("random");
        end

        // Backpressure with an extra in_valid that must be ignored
        accept(ABC_BLK, iv_vec, exp_abc);
        collect("bp", LAT);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            block_in = EMPTY_BLK;
            @(posedge clk);
            #1;
            chk("bp_out_valid", {255'd0, out_valid}, 256'd1);
            chk("bp_digest", digest, exp_abc);
            chk("bp_in_ready", {255'd0, in_ready}, 256'd0);
        end
        release_out("bp");
        repeat (LAT + 5) @(posedge clk);
        #1 chk("bp_not_queued", {255'd0, out_valid}, 256'd0);

        // Back-to-back: in_valid and out_ready held high
        @(negedge clk);
        block_in  = ABC_BLK;
        hash_in   = iv_vec;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        chk("b2b_in_ready", {255'd0, in_ready}, 256'd1);
        @(posedge clk);
        exp_q.push_back(exp_abc);
        @(negedge clk) block_in = EMPTY_BLK;
        collect("b2b_first", LAT);
        exp_q.push_back(exp_empty);
        @(posedge clk);
        #1;
        chk("b2b_exit_valid", {255'd0, out_valid}, 256'd0);
        chk("b2b_exit_ready", {255'd0, in_ready}, 256'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("b2b_second_taken", {255'd0, in_ready}, 256'd0);
        collect("b2b_second", LAT);
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("b2b_done_valid", {255'd0, out_valid}, 256'd0);

        // Asynchronous reset in the middle of round 30
        accept(ABC_BLK, iv_vec, exp_abc);
        repeat (30) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_in_ready", {255'd0, in_ready}, 256'd1);
        chk("abort_out_valid", {255'd0, out_valid}, 256'd0);
        chk("abort_digest", digest, 256'd0);
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        accept(ABC_BLK, iv_vec, exp_abc);
        collect("after_abort", LAT);
        release_out("after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
